// File: rtl/debug_capture_buffer.sv
// debug_capture_buffer
// Trigger-based capture memory for 30-bit fabric samples. A ring buffer keeps
// pre-trigger history, a fixed number of post-trigger samples is recorded, and
// the window then freezes for readout by logical index (0 = oldest sample).
module debug_capture_buffer #(
   parameter int DEPTH     = 1024,
   parameter int POST_TRIG = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic        trigger,
   input  logic        sample_valid,
   input  logic [29:0] sample_data,
   input  logic        rd_en,
   input  logic [17:0] rd_addr,
   output logic [29:0] rd_data,
   output logic [1:0]  state,
   output logic        done,
   output logic [17:0] valid_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PCW = $clog2(POST_TRIG + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         st;
   logic [AW-1:0]  wp;
   logic [AW-1:0]  start_ptr;
   logic           wrapped;
   logic [PCW-1:0] post_cnt;

   logic [29:0]    mem [DEPTH];
   logic [29:0]    ram_q;
   logic           rd_zero;

   logic           post_full;
   logic           wr_en;
   logic           post_inc;
   logic [AW-1:0]  rd_phys;
   logic           rd_oob;

   assign state = st;

   // The last post-trigger sample has landed; the following cycle only freezes.
   assign post_full = (post_cnt == PCW'(POST_TRIG));

   // A write happens for every qualified sample while collecting; arm takes
   // priority and discards a sample arriving in the same cycle.
   assign wr_en = sample_valid && !arm &&
                  ((st == ARMED) || ((st == CAPTURE) && !post_full));

   // The trigger-cycle sample is post-trigger sample 1.
   assign post_inc = wr_en && ((st == CAPTURE) || trigger);

   assign rd_phys = start_ptr + rd_addr[AW-1:0];
   assign rd_oob  = (st != DONE) || (rd_addr >= valid_count);

   // Capture control: arm restarts from any state, otherwise advance the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= IDLE;
         done        <= 1'b0;
         valid_count <= '0;
         wp          <= '0;
         wrapped     <= 1'b0;
         post_cnt    <= '0;
         start_ptr   <= '0;
      end else if (arm) begin
         st       <= ARMED;
         done     <= 1'b0;
         wp       <= '0;
         wrapped  <= 1'b0;
         post_cnt <= '0;
      end else begin
         if (wr_en) begin
            wp <= wp + AW'(1);
            if (wp == '1) begin
               wrapped <= 1'b1;
            end
         end
         if (post_inc) begin
            post_cnt <= post_cnt + PCW'(1);
         end
         case (st)
            ARMED: begin
               if (trigger) begin
                  st <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (post_full) begin
                  st          <= DONE;
                  done        <= 1'b1;
                  start_ptr   <= wrapped ? wp : '0;
                  valid_count <= wrapped ? 18'(DEPTH) : 18'(wp);
               end
            end
            default: ;
         endcase
      end
   end

   // Sample storage with one synchronous write and one synchronous read port.
   // NOTE: the array is deliberately left out of reset so it infers block RAM;
   // reads after reset are masked by rd_zero instead of clearing the contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp] <= sample_data;
      end
      if (rd_en) begin
         ram_q <= mem[rd_phys];
      end
   end

   // Registered "return zero" flag for reads outside DONE or past the window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_zero <= 1'b1;
      end else if (rd_en) begin
         rd_zero <= rd_oob;
      end
   end

   assign rd_data = rd_zero ? '0 : ram_q;

endmodule

// File: tb/tb_debug_capture_buffer.sv
// Testbench for debug_capture_buffer (DEPTH=16, POST_TRIG=4). A queue holds every
// sample accepted since the last arm; the readable window is the newest
// min(count, DEPTH) entries, oldest first.
module tb_debug_capture_buffer;

   localparam int DEPTH     = 16;
   localparam int POST_TRIG = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        arm;
   logic        trigger;
   logic        sample_valid;
   logic [29:0] sample_data;
   logic        rd_en;
   logic [17:0] rd_addr;
   logic [29:0] rd_data;
   logic [1:0]  state;
   logic        done;
   logic [17:0] valid_count;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [29:0] hist [$];

   debug_capture_buffer #(
      .DEPTH     (DEPTH),
      .POST_TRIG (POST_TRIG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm),
      .trigger      (trigger),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .state        (state),
      .done         (done),
      .valid_count  (valid_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_arm();
      arm          = 1'b1;
      trigger      = 1'b0;
      sample_valid = 1'b0;
      tick();
      arm = 1'b0;
      hist.delete();
   endtask

   // Optional random idle gap, then one sample (optionally with trigger).
   task automatic send(input logic [29:0] d, input bit trig, input int gap_max);
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) tick();
      end
      sample_valid = 1'b1;
      sample_data  = d;
      trigger      = trig;
      tick();
      hist.push_back(d);
      sample_valid = 1'b0;
      trigger      = 1'b0;
      sample_data  = '0;
   endtask

   // Keep streaming junk until DONE (bounded); none of it may be stored.
   task automatic finish_capture(input string tag);
      int cyc = 0;
      while (!done && cyc < 10) begin
         sample_valid = 1'b1;
         sample_data  = 30'($urandom);
         tick();
         cyc++;
      end
      sample_valid = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_state"}, 32'(state), 32'd3);
   endtask

   task automatic run_capture(input string tag, input int n_pre, input int gap, input bit rnd);
      do_arm();
      for (int i = 0; i < n_pre; i++) begin
         send(rnd ? 30'($urandom) : 30'(i + 1), 1'b0, gap);
      end
      for (int j = 0; j < POST_TRIG; j++) begin
         send(rnd ? 30'($urandom) : 30'(n_pre + 1 + j), (j == 0), gap);
      end
      finish_capture(tag);
   endtask

   task automatic verify_window(input string tag);
      int n  = hist.size();
      int vc = (n < DEPTH) ? n : DEPTH;
      logic [29:0] e;
      check({tag, "_vc"}, 32'(valid_count), 32'(vc));
      for (int i = 0; i < DEPTH + 2; i++) begin
         rd_en   = 1'b1;
         rd_addr = 18'(i);
         tick();
         e = (i < vc) ? hist[n - vc + i] : 30'd0;
         check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(e));
      end
      rd_en = 1'b0;
   endtask

   initial begin
      logic [29:0] held;
      reset        = 1'b1;
      arm          = 1'b0;
      trigger      = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      rd_en        = 1'b0;
      rd_addr      = '0;
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_vc", 32'(valid_count), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Trigger and samples in IDLE are ignored.
      sample_valid = 1'b1;
      trigger      = 1'b1;
      sample_data  = 30'h3abc;
      tick();
      sample_valid = 1'b0;
      trigger      = 1'b0;
      check("idle_trig", 32'(state), 32'd0);

      // Basic capture: 3 pre, trigger with 4, then 5..7.
      run_capture("s1", 3, 0, 1'b0);
      verify_window("s1");

      // Read while ARMED returns zero although the RAM holds old data.
      do_arm();
      check("armed_state", 32'(state), 32'd1);
      rd_en   = 1'b1;
      rd_addr = 18'd0;
      tick();
      rd_en = 1'b0;
      check("rd_armed", 32'(rd_data), 32'd0);

      // arm + trigger together: arm wins, capture restarts from empty.
      for (int i = 0; i < 3; i++) send(30'(100 + i), 1'b0, 0);
      arm          = 1'b1;
      trigger      = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 30'h1234;
      tick();
      arm          = 1'b0;
      trigger      = 1'b0;
      sample_valid = 1'b0;
      hist.delete();
      check("arm_trig_state", 32'(state), 32'd1);
      for (int j = 0; j < POST_TRIG; j++) send(30'(200 + j), (j == 0), 0);
      finish_capture("at");
      verify_window("at");

      // Wrap: 40 pre-trigger samples, then 41..44.
      run_capture("wrap", 40, 0, 1'b0);
      verify_window("wrap");
      check("wrap_idx0_model", 32'(hist[hist.size() - DEPTH]), 32'd29);

      // rd_data holds while rd_en is low.
      rd_en   = 1'b1;
      rd_addr = 18'd5;
      tick();
      rd_en = 1'b0;
      held  = hist[hist.size() - DEPTH + 5];
      check("hold_first", 32'(rd_data), 32'(held));
      for (int k = 0; k < 4; k++) begin
         rd_addr = 18'($urandom_range(0, DEPTH - 1));
         tick();
         check($sformatf("hold_%0d", k), 32'(rd_data), 32'(held));
      end

      // Asynchronous reset in the middle of a capture.
      do_arm();
      send(30'd501, 1'b0, 0);
      send(30'd502, 1'b0, 0);
      send(30'd503, 1'b1, 0);
      send(30'd504, 1'b0, 0);
      #3;
      reset = 1'b1;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_vc", 32'(valid_count), 32'd0);
      check("arst_rd", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      run_capture("s1r", 3, 0, 1'b0);
      verify_window("s1r");

      // Same capture with random idle cycles between samples.
      run_capture("gap", 3, 3, 1'b0);
      verify_window("gap");

      // Randomized captures with random history length and data.
      for (int k = 0; k < 3; k++) begin
         run_capture($sformatf("rnd%0d", k), int'($urandom_range(0, 30)), 2, 1'b1);
         verify_window($sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/debug_capture_buffer.md
# debug_capture_buffer

Trigger-based sample capture memory feeding the SPI debug register block's RAM readout opcodes (0xBA 16-bit, 0xBB 32-bit). Fabric logic streams 30-bit samples in. A pre-trigger ring buffer keeps recent history, then a fixed number of post-trigger samples is recorded and the buffer freezes. The SPI block then reads the frozen window by logical index through `rd_addr`/`rd_en`/`rd_data`, where index 0 is the oldest sample.

## Interface
- `DEPTH`, 1024: sample storage depth. Power of two, 2..131072.
- `POST_TRIG`, 512: samples recorded from the trigger onward. 1 ≤ POST_TRIG < DEPTH.
- `clk` in 1: system clock. Same clock as the SPI block.
- `reset` in 1: asynchronous, active-high reset.
- `arm` in 1: single-cycle pulse that starts or restarts a capture.
- `trigger` in 1: level, sampled only in ARMED.
- `sample_valid` in 1: qualifies `sample_data` this cycle.
- `sample_data` in 30: sample payload.
- `rd_en` in 1: read enable from the SPI block.
- `rd_addr` in 18: logical read index, 0 = oldest sample.
- `rd_data` out 30: registered read data.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- `done` out 1: high while in DONE.
- `valid_count` out 18: number of readable samples. Meaningful in DONE.

## Operation
- Internal registers:
  - `wp`: write pointer, log2(DEPTH) bits.
  - `wrapped`: set once `wp` has wrapped.
  - `post_cnt`: post-trigger sample counter.
  - `start_ptr`: physical address of the oldest sample.
- IDLE:
  - Samples are ignored.
  - `arm` → ARMED with `wp`=0, `wrapped`=0, `post_cnt`=0.
- ARMED:
  - Each `sample_valid` writes `mem[wp]`, then `wp`++ mod DEPTH.
  - `wrapped` sets when `wp` rolls from DEPTH-1 to 0.
  - `trigger` high → CAPTURE. A sample arriving in the trigger cycle is written and counts as post-trigger sample 1.
- CAPTURE:
  - Writing continues as in ARMED, and `post_cnt` increments per sample.
  - On the write that brings `post_cnt` to POST_TRIG, enter DONE on the next cycle and latch:
    - `start_ptr` = `wrapped` ? `wp` : 0, using `wp` after that final write.
    - `valid_count` = `wrapped` ? DEPTH : `wp`.
- DONE:
  - No writes occur; the memory is frozen.
  - `arm` → ARMED, which restarts the capture and clears `done`.
- `arm` in ARMED or CAPTURE restarts the capture. Memory contents are not cleared.
- Simultaneous `arm` and `trigger`: `arm` wins and `trigger` is ignored that cycle.
- `trigger` in IDLE, CAPTURE or DONE is ignored.
- Reads:
  - When `rd_en`=1, the physical address is (`start_ptr` + `rd_addr`[log2(DEPTH)-1:0]) mod DEPTH.
  - `rd_data` returns 0 if state ≠ DONE or `rd_addr` ≥ `valid_count`.
  - When `rd_en`=0, `rd_data` holds its last value.
- Arithmetic:
  - All pointer math wraps modulo DEPTH.
  - `valid_count` is zero-extended to 18 bits. DEPTH=131072 fits.
- Storage: a single inferred RAM with a synchronous read port and a synchronous write port (EBR).

## Timing
- Reset values: `state`=IDLE, `done`=0, `valid_count`=0, `rd_data`=0, `wp`=0, `wrapped`=0, `post_cnt`=0, `start_ptr`=0.
- Memory contents are undefined after reset.
- `arm` sampled high at edge N: `state`=ARMED after edge N. A `sample_valid` at edge N is not written.
- Write latency: a sample at edge N is in memory and readable from edge N+1 once DONE.
- DONE entry: `done` and `valid_count` update at the edge after the final post-trigger write.
- Read latency: 1 cycle. `rd_addr` sampled with `rd_en`=1 at edge N gives `rd_data` valid after edge N.
- The SPI block changes `rd_addr` at most once per SCK bit, which is at least 4 clocks apart, so it always sees settled data.
- Reset asserted mid-capture or mid-read: the block returns to IDLE immediately, asynchronously. An in-flight SPI readout then returns 0s.
- Back-to-back samples every cycle are supported. There is no backpressure.

## Test plan
- DEPTH=16, POST_TRIG=4:
  - Stimulus: `arm`, then 3 samples 0x1..0x3, trigger with sample 0x4, then samples 0x5..0x7.
  - Response: `done`, `valid_count`=7; indices 0..6 read 0x1..0x7; index 7 reads 0.
- Wrap case:
  - Stimulus: 40 samples 1..40 before `trigger`, then 4 post-trigger samples 41..44.
  - Response: `valid_count`=16; index 0 reads 29; index 15 reads 44.
- Simultaneous `arm` and `trigger` in ARMED:
  - Response: stays ARMED, `wp`=0, and a later trigger with 4 samples reaches DONE with `valid_count`=4.
- Read before DONE:
  - Stimulus: `rd_en`=1 with `rd_addr`=0 in ARMED.
  - Response: `rd_data`=0.
  - Then in DONE with `rd_en` low and `rd_addr` changing: `rd_data` holds its value.
- Reset mid-CAPTURE:
  - Stimulus: assert `reset` between clock edges.
  - Response: `state`=0, `done`=0, `valid_count`=0 without waiting for a clock edge. A subsequent full capture passes the first scenario.
- `sample_valid` gaps:
  - Stimulus: random idle cycles between the 7 samples of the first scenario.
  - Response: the same results as the first scenario.
